// File: rtl/vec_mem_arbiter_if.sv
// Native picorv32-style memory bus bundle: two requester ports and one downstream port.
// The arbiter takes the slave view; the environment (core, coprocessor, memory) takes the master view.
interface vec_mem_arbiter_if;
  logic        cpu_mem_valid;
  logic        cpu_mem_instr;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;

  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr;
  logic [31:0] vec_mem_wdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic [31:0] vec_mem_rdata;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
    output cpu_mem_ready, cpu_mem_rdata,
    input  vec_mem_valid, vec_mem_addr, vec_mem_wdata, vec_mem_wstrb,
    output vec_mem_ready, vec_mem_rdata,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport master (
    output cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
    input  cpu_mem_ready, cpu_mem_rdata,
    output vec_mem_valid, vec_mem_addr, vec_mem_wdata, vec_mem_wstrb,
    input  vec_mem_ready, vec_mem_rdata,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/vec_mem_arbiter.sv
// Round-robin, transaction-locked arbiter sharing one memory port between the core and the
// vector coprocessor, with a downstream-stall watchdog and a sticky timeout flag.
module vec_mem_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  vec_mem_arbiter_if.slave  bus,
  output logic              grant_vec,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_VEC} state_t;

  localparam logic LAST_VEC = 1'b1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_reg;
  logic             last_grant_reg;
  logic [CNT_W-1:0] wdog_cnt_reg;
  logic             err_timeout_reg;

  logic in_cpu, in_vec, owner_valid, wdog_expire;

  assign in_cpu      = (state_reg == GNT_CPU);
  assign in_vec      = (state_reg == GNT_VEC);
  assign owner_valid = (in_cpu && bus.cpu_mem_valid) || (in_vec && bus.vec_mem_valid);
  // The watchdog fires on the TIMEOUT-th granted cycle without mem_ready.
  assign wdog_expire = (TIMEOUT > 0) && !bus.mem_ready && (wdog_cnt_reg == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_grant_reg  <= LAST_VEC;
      wdog_cnt_reg    <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          wdog_cnt_reg <= '0;
          if (bus.cpu_mem_valid && (!bus.vec_mem_valid || last_grant_reg == LAST_VEC))
            state_reg <= GNT_CPU;
          else if (bus.vec_mem_valid)
            state_reg <= GNT_VEC;
        end
        GNT_CPU, GNT_VEC: begin
          // Completion beats both an abandoned request and a watchdog expiry.
          if (bus.mem_ready) begin
            state_reg      <= IDLE;
            last_grant_reg <= in_vec;
            wdog_cnt_reg   <= '0;
          end else if (!owner_valid) begin
            state_reg    <= IDLE;
            wdog_cnt_reg <= '0;
          end else if (wdog_expire) begin
            state_reg       <= IDLE;
            last_grant_reg  <= in_vec;
            err_timeout_reg <= 1'b1;
            wdog_cnt_reg    <= '0;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Downstream mux; everything is forced quiet while reset is asserted, even mid-transaction.
  assign bus.mem_valid     = !reset && owner_valid;
  assign bus.mem_instr     = !reset && in_cpu && bus.cpu_mem_instr;
  assign bus.mem_addr      = reset ? 32'd0 : in_cpu ? bus.cpu_mem_addr  : in_vec ? bus.vec_mem_addr  : 32'd0;
  assign bus.mem_wdata     = reset ? 32'd0 : in_cpu ? bus.cpu_mem_wdata : in_vec ? bus.vec_mem_wdata : 32'd0;
  assign bus.mem_wstrb     = reset ? 4'd0  : in_cpu ? bus.cpu_mem_wstrb : in_vec ? bus.vec_mem_wstrb : 4'd0;

  assign bus.cpu_mem_ready = !reset && in_cpu && bus.mem_ready;
  assign bus.vec_mem_ready = !reset && in_vec && bus.mem_ready;
  assign bus.cpu_mem_rdata = bus.mem_rdata;
  assign bus.vec_mem_rdata = bus.mem_rdata;

  assign grant_vec   = !reset && in_vec;
  assign err_timeout = !reset && err_timeout_reg;
endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: directed scenarios plus a randomized phase, each cycle checked
// against a transaction-level model of ownership, round-robin order and the watchdog.
module tb_vec_mem_arbiter;
  localparam int TIMEOUT = 4;

  logic clk;
  logic rst;
  logic grant_vec;
  logic err_timeout;

  vec_mem_arbiter_if bus ();

  vec_mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(9)) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .grant_vec  (grant_vec),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // requester side: index 0 = core, 1 = coprocessor
  logic        rq_valid [2];
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic [3:0]  rq_wstrb [2];
  logic        cpu_instr;
  logic        drop_vec;
  logic [31:0] last_rdata [2];
  int          cnt_rdy [2];
  int          order [$];

  // downstream memory and its latency model
  logic [31:0] mem_words [0:255];
  logic        stall;
  int          lat, lat_cnt, max_lat;

  // reference model: who owns the port (-1 = nobody), who was served last, stall age
  int owner   = -1;
  int last_g  = 1;
  int waited  = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic        mr, mv, iv0, iv1, r;
    logic [31:0] ma, mwd;
    logic [3:0]  mws;
    int          own;
    bit          done [2];
    iv0 = rq_valid[0];
    iv1 = rq_valid[1];
    r   = rst;
    bus.cpu_mem_valid = rq_valid[0];
    bus.cpu_mem_instr = cpu_instr;
    bus.cpu_mem_addr  = rq_addr[0];
    bus.cpu_mem_wdata = rq_wdata[0];
    bus.cpu_mem_wstrb = rq_wstrb[0];
    bus.vec_mem_valid = rq_valid[1];
    bus.vec_mem_addr  = rq_addr[1];
    bus.vec_mem_wdata = rq_wdata[1];
    bus.vec_mem_wstrb = rq_wstrb[1];
    bus.mem_ready     = 1'b0;
    #1;
    mv  = bus.mem_valid;
    ma  = bus.mem_addr;
    mwd = bus.mem_wdata;
    mws = bus.mem_wstrb;
    mr  = mv && !stall && (lat_cnt >= lat);
    bus.mem_ready = mr;
    bus.mem_rdata = mr ? mem_words[ma[9:2]] : $urandom;
    #1;
    own = r ? -1 : owner;
    chk("mem_valid",   {31'd0, bus.mem_valid},     (own >= 0) ? {31'd0, rq_valid[own]} : 32'd0);
    chk("cpu_ready",   {31'd0, bus.cpu_mem_ready}, {31'd0, (own == 0) && mr});
    chk("vec_ready",   {31'd0, bus.vec_mem_ready}, {31'd0, (own == 1) && mr});
    chk("grant_vec",   {31'd0, grant_vec},         {31'd0, own == 1});
    chk("err_timeout", {31'd0, err_timeout},       {31'd0, !r && exp_err});
    chk("mem_addr",    bus.mem_addr,               (own >= 0) ? rq_addr[own] : 32'd0);
    chk("mem_wdata",   bus.mem_wdata,              (own >= 0) ? rq_wdata[own] : 32'd0);
    chk("mem_wstrb",   {28'd0, bus.mem_wstrb},     (own >= 0) ? {28'd0, rq_wstrb[own]} : 32'd0);
    chk("mem_instr",   {31'd0, bus.mem_instr},     {31'd0, (own == 0) && cpu_instr});
    done[0] = (own == 0) && mr;
    done[1] = (own == 1) && mr;
    if (done[0] && rq_wstrb[0] == 4'd0) chk("cpu_rdata", bus.cpu_mem_rdata, mem_words[rq_addr[0][9:2]]);
    if (done[1] && rq_wstrb[1] == 4'd0) chk("vec_rdata", bus.vec_mem_rdata, mem_words[rq_addr[1][9:2]]);
    if (done[0]) last_rdata[0] = bus.cpu_mem_rdata;
    if (done[1]) last_rdata[1] = bus.vec_mem_rdata;

    @(posedge clk);
    if (mv && mr)
      for (int b = 0; b < 4; b++)
        if (mws[b]) mem_words[ma[9:2]][8*b +: 8] = mwd[8*b +: 8];
    if (!mv || mr) begin
      lat_cnt = 0;
      lat = $urandom_range(max_lat, 0);
    end else begin
      lat_cnt++;
    end

    // model: one bubble to arbitrate, locked until ready / abandon / watchdog
    if (r) begin
      owner = -1; last_g = 1; waited = 0; exp_err = 1'b0;
    end else if (owner < 0) begin
      waited = 0;
      if (iv0 && iv1)  owner = 1 - last_g;
      else if (iv0)    owner = 0;
      else if (iv1)    owner = 1;
    end else if (mr) begin
      last_g = owner; owner = -1;
    end else if (!((owner == 0) ? iv0 : iv1)) begin
      owner = -1;
    end else if (waited + 1 >= TIMEOUT) begin
      exp_err = 1'b1; last_g = owner; owner = -1;
    end else begin
      waited++;
    end

    for (int x = 0; x < 2; x++) begin
      if (done[x]) begin
        order.push_back(x);
        cnt_rdy[x]++;
        rq_valid[x] = 1'b0;
        $display("txn %s addr=%h wstrb=%h data=%h", (x == 0) ? "cpu" : "vec",
                 rq_addr[x], rq_wstrb[x], (rq_wstrb[x] != 0) ? rq_wdata[x] : last_rdata[x]);
      end
    end
    if (drop_vec && own == 1) begin
      rq_valid[1] = 1'b0;
      drop_vec = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int limit);
    for (int i = 0; i < limit && (rq_valid[0] || rq_valid[1]); i++) step();
    chk(tag, {31'd0, rq_valid[0] | rq_valid[1]}, 32'd0);
  endtask

  task automatic set_req(input int x, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    rq_addr[x]  = a;
    rq_wdata[x] = d;
    rq_wstrb[x] = s;
    rq_valid[x] = 1'b1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    mem_words[0] = 32'h3bc00093;
    stall = 1'b0; max_lat = 0; lat = 0; lat_cnt = 0; drop_vec = 1'b0;
    cnt_rdy[0] = 0; cnt_rdy[1] = 0;
    last_rdata[0] = '0; last_rdata[1] = '0;
    cpu_instr = 1'b1;
    set_req(0, 32'd0, 32'd0, 4'd0);
    set_req(1, 32'd800, 32'd0, 4'd0);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);

    // reset with both requesting, then continuous contention
    repeat (3) step();
    rst = 1'b0;
    order.delete();
    for (int i = 0; i < 60 && order.size() < 8; i++) begin
      rq_valid[0] = 1'b1;
      rq_valid[1] = 1'b1;
      step();
    end
    rq_valid[0] = 1'b0;
    rq_valid[1] = 1'b0;
    step();
    chk("contention_count", order.size(), 8);
    if (order.size() >= 8)
      for (int i = 0; i < 8; i++) chk("contention_order", order[i], i % 2);
    chk("cpu_pulses", cnt_rdy[0], 4);
    chk("vec_pulses", cnt_rdy[1], 4);

    // core-only fetch
    base = cnt_rdy[1];
    cnt_rdy[0] = 0;
    set_req(0, 32'd0, 32'd0, 4'd0);
    drain("cpu_read_bound", 20);
    step();
    chk("cpu_read_pulses", cnt_rdy[0], 1);
    chk("cpu_read_data", last_rdata[0], 32'h3bc00093);
    chk("cpu_read_vec_quiet", cnt_rdy[1], base);

    // coprocessor write then readback
    cpu_instr = 1'b0;
    set_req(1, 32'd800, 32'h01020304, 4'b1111);
    drain("vec_write_bound", 20);
    chk("vec_write_mem", mem_words[200], 32'h01020304);
    set_req(1, 32'd800, 32'd0, 4'd0);
    drain("vec_read_bound", 20);
    chk("vec_readback", last_rdata[1], 32'h01020304);

    // abandoned coprocessor request after the core was served last
    set_req(0, 32'd4, 32'd0, 4'd0);
    drain("cpu_pre_bound", 20);
    base = cnt_rdy[1];
    stall = 1'b1;
    drop_vec = 1'b1;
    set_req(1, 32'd808, 32'd0, 4'd0);
    repeat (4) step();
    stall = 1'b0;
    chk("violation_no_ready", cnt_rdy[1], base);
    order.delete();
    set_req(0, 32'd8, 32'd0, 4'd0);
    set_req(1, 32'd812, 32'd0, 4'd0);
    drain("violation_tie_bound", 30);
    if (order.size() >= 1) chk("violation_last_kept", order[0], 1);

    // watchdog: core stalls downstream, coprocessor waits behind it
    base = cnt_rdy[0];
    stall = 1'b1;
    set_req(0, 32'd16, 32'd0, 4'd0);
    step();
    set_req(1, 32'd20, 32'd0, 4'd0);
    repeat (5) step();
    chk("wdog_err", {31'd0, err_timeout}, 32'd1);
    chk("wdog_no_ready", cnt_rdy[0], base);
    chk("wdog_vec_next", {31'd0, grant_vec}, 32'd1);
    stall = 1'b0;
    order.delete();
    drain("wdog_bound", 30);
    chk("wdog_order_len", order.size(), 2);
    if (order.size() >= 2) begin
      chk("wdog_order0", order[0], 1);
      chk("wdog_order1", order[1], 0);
    end
    chk("wdog_err_sticky", {31'd0, err_timeout}, 32'd1);

    // randomized traffic with occasional long stalls and resets
    max_lat = 5;
    for (int n = 0; n < 600; n++) begin
      for (int x = 0; x < 2; x++)
        if (!rq_valid[x] && $urandom_range(2, 0) == 0)
          set_req(x, {22'd0, 8'($urandom), 2'b00}, $urandom,
                  ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'd0);
      cpu_instr = 1'($urandom);
      rst = ($urandom_range(99, 0) == 0);
      step();
    end
    rst = 1'b0;
    max_lat = 0;
    drain("final_drain_bound", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
